// File: rtl/multi_issue_sequencer.sv
// multi_issue_sequencer
//   Splits a fetch bundle of width_p pre-decoded descriptors into in-order
//   issue groups that respect RAW/WAW hazards, per-class (INT/FP) issue limits
//   and special-op boundaries. One group is handed out per accepted cycle.
//
// Ports
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   bundle_v_i              bundle present
//   slot_*_i                per-slot descriptor fields (slot k at bit k, or
//                           bits [k*W +: W] for register specifiers)
//   bundle_yumi_o           bundle fully consumed this cycle
//   flush_i                 discard current bundle
//   issue_v_o/issue_ready_i group handshake
//   issue_mask_o            slots in the current group
//   head_o                  first unissued slot index
//   group_count_o           accepted groups (wraps)
//   instr_count_o           accepted instructions (wraps)
module multi_issue_sequencer #(
  parameter int width_p          = 2,
  parameter int reg_addr_width_p = 5,
  parameter int max_int_p        = 1,
  parameter int max_fp_p         = 1,
  parameter int ptr_width_lp     = $clog2(width_p + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 bundle_v_i,
  input  logic [width_p-1:0]                   slot_v_i,
  input  logic [width_p-1:0]                   slot_fp_i,
  input  logic [width_p-1:0]                   slot_special_i,
  input  logic [width_p-1:0]                   slot_write_rd_i,
  input  logic [width_p-1:0]                   slot_rd_fp_i,
  input  logic [width_p*reg_addr_width_p-1:0]  slot_rd_i,
  input  logic [width_p-1:0]                   slot_read_rs1_i,
  input  logic [width_p-1:0]                   slot_read_rs2_i,
  input  logic [width_p-1:0]                   slot_rs_fp_i,
  input  logic [width_p*reg_addr_width_p-1:0]  slot_rs1_i,
  input  logic [width_p*reg_addr_width_p-1:0]  slot_rs2_i,
  output logic                                 bundle_yumi_o,
  input  logic                                 flush_i,
  output logic                                 issue_v_o,
  input  logic                                 issue_ready_i,
  output logic [width_p-1:0]                   issue_mask_o,
  output logic [ptr_width_lp-1:0]              head_o,
  output logic [31:0]                          group_count_o,
  output logic [31:0]                          instr_count_o
);

  localparam int unsigned max_int_lp = max_int_p;
  localparam int unsigned max_fp_lp  = max_fp_p;
  localparam int unsigned rw_lp      = reg_addr_width_p;

  logic [ptr_width_lp-1:0] head_r, head_n;
  logic [31:0]             group_cnt_r, instr_cnt_r;

  logic [width_p-1:0]      mask;
  logic                    any_at_head, any_after_next;
  logic                    stop, spec_seen, ok, hazard;
  logic                    raw, waw;
  int unsigned             int_cnt, fp_cnt, last_idx;
  logic [rw_lp-1:0]        rd_i, rd_j, rs1_j, rs2_j;
  logic [ptr_width_lp-1:0] next_head;
  logic [31:0]             pop;
  logic                    accept, empty;

  // Group formation: single in-order scan from head_r; the scan stops at the
  // first valid slot that cannot join, invalid slots are simply passed over.
  always_comb begin
    mask        = '0;
    any_at_head = 1'b0;
    stop        = 1'b0;
    spec_seen   = 1'b0;
    ok          = 1'b0;
    hazard      = 1'b0;
    raw         = 1'b0;
    waw         = 1'b0;
    int_cnt     = 0;
    fp_cnt      = 0;
    last_idx    = 0;
    rd_i        = '0;
    rd_j        = '0;
    rs1_j       = '0;
    rs2_j       = '0;
    for (int unsigned j = 0; j < width_p; j++) begin
      if (j >= 32'(head_r)) begin
        if (slot_v_i[j]) any_at_head = 1'b1;
        if (slot_v_i[j] && !stop) begin
          if (mask == '0) begin
            ok = 1'b1;
          end else begin
            rd_j   = slot_rd_i [j*rw_lp +: rw_lp];
            rs1_j  = slot_rs1_i[j*rw_lp +: rw_lp];
            rs2_j  = slot_rs2_i[j*rw_lp +: rw_lp];
            hazard = 1'b0;
            for (int unsigned i = 0; i < j; i++) begin
              rd_i = slot_rd_i[i*rw_lp +: rw_lp];
              // INT x0 is hard-wired zero; FP f0 is a real register
              raw = mask[i] && slot_write_rd_i[i]
                    && (slot_rd_fp_i[i] == slot_rs_fp_i[j])
                    && ((slot_read_rs1_i[j] && (rd_i == rs1_j))
                     || (slot_read_rs2_i[j] && (rd_i == rs2_j)))
                    && !(!slot_rd_fp_i[i] && (rd_i == '0));
              waw = mask[i] && slot_write_rd_i[i] && slot_write_rd_i[j]
                    && (slot_rd_fp_i[i] == slot_rd_fp_i[j])
                    && (rd_i == rd_j)
                    && !(!slot_rd_fp_i[i] && (rd_i == '0));
              if (raw || waw) hazard = 1'b1;
            end
            ok = !spec_seen && !hazard
                 && (slot_fp_i[j] ? (fp_cnt < max_fp_lp) : (int_cnt < max_int_lp));
          end
          if (ok) begin
            mask[j]  = 1'b1;
            last_idx = j;
            if (slot_fp_i[j]) fp_cnt  = fp_cnt + 1;
            else              int_cnt = int_cnt + 1;
            if (slot_special_i[j]) spec_seen = 1'b1;
          end else begin
            stop = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    any_after_next = 1'b0;
    pop            = '0;
    for (int unsigned j = 0; j < width_p; j++) begin
      if ((j > last_idx) && slot_v_i[j]) any_after_next = 1'b1;
      pop = pop + 32'(mask[j]);
    end
  end

  assign next_head    = ptr_width_lp'(last_idx + 1);
  assign issue_mask_o = mask;
  assign issue_v_o    = bundle_v_i & (|mask) & ~flush_i;
  assign accept       = issue_v_o & issue_ready_i;
  assign empty        = bundle_v_i & ~any_at_head;

  always_comb begin
    bundle_yumi_o = 1'b0;
    head_n        = head_r;
    if (flush_i) begin
      bundle_yumi_o = bundle_v_i;
      head_n        = '0;
    end else if (empty) begin
      bundle_yumi_o = 1'b1;
      head_n        = '0;
    end else if (accept) begin
      bundle_yumi_o = ~any_after_next;
      head_n        = any_after_next ? next_head : '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_r      <= '0;
      group_cnt_r <= '0;
      instr_cnt_r <= '0;
    end else begin
      head_r <= head_n;
      if (accept) begin
        group_cnt_r <= group_cnt_r + 32'd1;
        instr_cnt_r <= instr_cnt_r + pop;
      end
    end
  end

  assign head_o        = head_r;
  assign group_count_o = group_cnt_r;
  assign instr_count_o = instr_cnt_r;

endmodule

// File: tb/tb_multi_issue_sequencer.sv
module tb_multi_issue_sequencer;

  typedef struct packed {
    logic v, fp, sp, wr, rdfp;
    logic [4:0] rd;
    logic r1, r2, rsfp;
    logic [4:0] rs1, rs2;
  } desc_t;

  typedef struct packed {
    logic [7:0] mask;
    logic       yumi;
    logic [3:0] head;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  exp_t qa[$];
  exp_t qb[$];

  // ---------------- instance A: width 2, 1 INT + 1 FP ----------------
  desc_t a_d[2];
  logic a_bv = 1'b0, a_flush = 1'b0, a_ready = 1'b0;
  logic [1:0] a_v, a_fp, a_sp, a_wr, a_rdfp, a_r1, a_r2, a_rsfp;
  logic [9:0] a_rd, a_rs1, a_rs2;
  logic a_yumi, a_issue_v;
  logic [1:0] a_mask, a_head;
  logic [31:0] a_gc, a_ic;

  always_comb begin
    a_v = '0; a_fp = '0; a_sp = '0; a_wr = '0; a_rdfp = '0;
    a_r1 = '0; a_r2 = '0; a_rsfp = '0; a_rd = '0; a_rs1 = '0; a_rs2 = '0;
    for (int k = 0; k < 2; k++) begin
      a_v[k] = a_d[k].v;   a_fp[k] = a_d[k].fp;   a_sp[k] = a_d[k].sp;
      a_wr[k] = a_d[k].wr; a_rdfp[k] = a_d[k].rdfp;
      a_r1[k] = a_d[k].r1; a_r2[k] = a_d[k].r2;   a_rsfp[k] = a_d[k].rsfp;
      a_rd[k*5 +: 5] = a_d[k].rd;
      a_rs1[k*5 +: 5] = a_d[k].rs1;
      a_rs2[k*5 +: 5] = a_d[k].rs2;
    end
  end

  multi_issue_sequencer u_a (
    .clk_i(clk), .reset_n_i(rst_n), .bundle_v_i(a_bv),
    .slot_v_i(a_v), .slot_fp_i(a_fp), .slot_special_i(a_sp),
    .slot_write_rd_i(a_wr), .slot_rd_fp_i(a_rdfp), .slot_rd_i(a_rd),
    .slot_read_rs1_i(a_r1), .slot_read_rs2_i(a_r2), .slot_rs_fp_i(a_rsfp),
    .slot_rs1_i(a_rs1), .slot_rs2_i(a_rs2),
    .bundle_yumi_o(a_yumi), .flush_i(a_flush), .issue_v_o(a_issue_v),
    .issue_ready_i(a_ready), .issue_mask_o(a_mask), .head_o(a_head),
    .group_count_o(a_gc), .instr_count_o(a_ic)
  );

  // ---------------- instance B: width 4, 2 INT + 1 FP ----------------
  desc_t b_d[4];
  logic b_bv = 1'b0, b_flush = 1'b0, b_ready = 1'b0;
  logic [3:0] b_v, b_fp, b_sp, b_wr, b_rdfp, b_r1, b_r2, b_rsfp;
  logic [19:0] b_rd, b_rs1, b_rs2;
  logic b_yumi, b_issue_v;
  logic [3:0] b_mask;
  logic [2:0] b_head;
  logic [31:0] b_gc, b_ic;

  always_comb begin
    b_v = '0; b_fp = '0; b_sp = '0; b_wr = '0; b_rdfp = '0;
    b_r1 = '0; b_r2 = '0; b_rsfp = '0; b_rd = '0; b_rs1 = '0; b_rs2 = '0;
    for (int k = 0; k < 4; k++) begin
      b_v[k] = b_d[k].v;   b_fp[k] = b_d[k].fp;   b_sp[k] = b_d[k].sp;
      b_wr[k] = b_d[k].wr; b_rdfp[k] = b_d[k].rdfp;
      b_r1[k] = b_d[k].r1; b_r2[k] = b_d[k].r2;   b_rsfp[k] = b_d[k].rsfp;
      b_rd[k*5 +: 5] = b_d[k].rd;
      b_rs1[k*5 +: 5] = b_d[k].rs1;
      b_rs2[k*5 +: 5] = b_d[k].rs2;
    end
  end

  multi_issue_sequencer #(.width_p(4), .max_int_p(2), .max_fp_p(1)) u_b (
    .clk_i(clk), .reset_n_i(rst_n), .bundle_v_i(b_bv),
    .slot_v_i(b_v), .slot_fp_i(b_fp), .slot_special_i(b_sp),
    .slot_write_rd_i(b_wr), .slot_rd_fp_i(b_rdfp), .slot_rd_i(b_rd),
    .slot_read_rs1_i(b_r1), .slot_read_rs2_i(b_r2), .slot_rs_fp_i(b_rsfp),
    .slot_rs1_i(b_rs1), .slot_rs2_i(b_rs2),
    .bundle_yumi_o(b_yumi), .flush_i(b_flush), .issue_v_o(b_issue_v),
    .issue_ready_i(b_ready), .issue_mask_o(b_mask), .head_o(b_head),
    .group_count_o(b_gc), .instr_count_o(b_ic)
  );

  // ---------------- helpers ----------------
  function automatic desc_t mk(bit fp, bit sp, bit wr, bit rdfp, int rd,
                               bit r1, int rs1, bit r2, int rs2, bit rsfp);
    desc_t d;
    d.v = 1'b1; d.fp = fp; d.sp = sp; d.wr = wr; d.rdfp = rdfp;
    d.rd = 5'(rd); d.r1 = r1; d.rs1 = 5'(rs1); d.r2 = r2; d.rs2 = 5'(rs2);
    d.rsfp = rsfp;
    return d;
  endfunction

  // INT-class add rd <- rs1, rs2
  function automatic desc_t iadd(int rd, int rs1, int rs2);
    return mk(1'b0, 1'b0, 1'b1, 1'b0, rd, 1'b1, rs1, 1'b1, rs2, 1'b0);
  endfunction

  // FP-class fadd frd <- frs1, frs2
  function automatic desc_t fadd(int rd, int rs1, int rs2);
    return mk(1'b1, 1'b0, 1'b1, 1'b1, rd, 1'b1, rs1, 1'b1, rs2, 1'b1);
  endfunction

  function automatic void pa(logic [7:0] m, logic y, logic [3:0] h);
    exp_t e;
    e.mask = m; e.yumi = y; e.head = h;
    qa.push_back(e);
  endfunction

  function automatic void pb(logic [7:0] m, logic y, logic [3:0] h);
    exp_t e;
    e.mask = m; e.yumi = y; e.head = h;
    qb.push_back(e);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  exp_t ea, eb;
  always @(negedge clk) begin
    if (a_issue_v && a_ready) begin
      vectors++;
      if (qa.size() == 0) begin
        miscompares++;
        $display("FAIL grp_a unexpected group mask=%b head=%0d", a_mask, a_head);
      end else begin
        ea = qa.pop_front();
        if ({6'b0, a_mask} !== ea.mask || a_yumi !== ea.yumi || {2'b0, a_head} !== ea.head) begin
          miscompares++;
          $display("FAIL grp_a got mask=%b yumi=%b head=%0d exp mask=%b yumi=%b head=%0d",
                   a_mask, a_yumi, a_head, ea.mask[1:0], ea.yumi, ea.head);
        end
      end
    end
    if (b_issue_v && b_ready) begin
      vectors++;
      if (qb.size() == 0) begin
        miscompares++;
        $display("FAIL grp_b unexpected group mask=%b head=%0d", b_mask, b_head);
      end else begin
        eb = qb.pop_front();
        if ({4'b0, b_mask} !== eb.mask || b_yumi !== eb.yumi || {1'b0, b_head} !== eb.head) begin
          miscompares++;
          $display("FAIL grp_b got mask=%b yumi=%b head=%0d exp mask=%b yumi=%b head=%0d",
                   b_mask, b_yumi, b_head, eb.mask[3:0], eb.yumi, eb.head);
        end
      end
    end
  end

  task automatic run_a(string name);
    bit done = 1'b0;
    a_bv = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (a_yumi) done = 1'b1;
      @(posedge clk); #1;
    end
    a_bv = 1'b0;
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_leftover"}, 32'(qa.size()), 32'd0);
  endtask

  task automatic run_b(string name);
    bit done = 1'b0;
    b_bv = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (b_yumi) done = 1'b1;
      @(posedge clk); #1;
    end
    b_bv = 1'b0;
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_leftover"}, 32'(qb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    for (int k = 0; k < 2; k++) a_d[k] = '0;
    for (int k = 0; k < 4; k++) b_d[k] = '0;
    #12;
    chk("rst_head_a", 32'(a_head), 32'd0);
    chk("rst_gc_a", a_gc, 32'd0);
    chk("rst_ic_a", a_ic, 32'd0);
    chk("rst_issue_v_a", 32'(a_issue_v), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // independent INT + FP -> one group
    a_ready = 1'b1;
    a_d[0] = iadd(5, 1, 2);
    a_d[1] = fadd(3, 1, 2);
    pa(8'b11, 1'b1, 4'd0);
    run_a("int_fp");
    chk("int_fp_gc", a_gc, 32'd1);
    chk("int_fp_ic", a_ic, 32'd2);

    // two INT ops -> two groups, head 0 -> 1 -> 0
    a_d[0] = iadd(5, 1, 2);
    a_d[1] = iadd(6, 3, 4);
    pa(8'b01, 1'b0, 4'd0);
    pa(8'b10, 1'b1, 4'd1);
    run_a("same_class");
    chk("same_class_head", 32'(a_head), 32'd0);

    // RAW through x7 into FP-class store base
    a_d[0] = iadd(7, 1, 2);
    a_d[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 7, 1'b0, 0, 1'b0);
    pa(8'b01, 1'b0, 4'd0);
    pa(8'b10, 1'b1, 4'd1);
    run_a("raw_x7");

    // same with x0: no hazard
    a_d[0] = iadd(0, 1, 2);
    a_d[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b0);
    pa(8'b11, 1'b1, 4'd0);
    run_a("raw_x0");

    // special op first, dispatch stalled for 3 cycles
    a_d[0] = mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1, 1'b1, 2, 1'b0);
    a_d[1] = fadd(4, 1, 2);
    a_ready = 1'b0;
    a_bv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_mask", 32'(a_mask), 32'b01);
      chk("hold_head", 32'(a_head), 32'd0);
      @(posedge clk); #1;
    end
    a_ready = 1'b1;
    pa(8'b01, 1'b0, 4'd0);
    pa(8'b10, 1'b1, 4'd1);
    run_a("special");

    // FP register f0 does cause RAW
    a_d[0] = mk(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1, 1'b1, 2, 1'b1);
    a_d[1] = mk(1'b0, 1'b0, 1'b1, 1'b0, 10, 1'b1, 0, 1'b0, 0, 1'b1);
    pa(8'b01, 1'b0, 4'd0);
    pa(8'b10, 1'b1, 4'd1);
    run_a("raw_f0");

    // WAW on x9 between INT add and FP->INT convert
    a_d[0] = iadd(9, 1, 2);
    a_d[1] = mk(1'b1, 1'b0, 1'b1, 1'b0, 9, 1'b1, 1, 1'b0, 0, 1'b1);
    pa(8'b01, 1'b0, 4'd0);
    pa(8'b10, 1'b1, 4'd1);
    run_a("waw_x9");
    chk("pre_flush_gc", a_gc, 32'd12);
    chk("pre_flush_ic", a_ic, 32'd14);

    // flush at head 1 with ready high: flush wins
    a_d[0] = iadd(5, 1, 2);
    a_d[1] = iadd(6, 3, 4);
    pa(8'b01, 1'b0, 4'd0);
    a_bv = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("flush_head_before", 32'(a_head), 32'd1);
    a_flush = 1'b1;
    @(negedge clk);
    chk("flush_issue_v", 32'(a_issue_v), 32'd0);
    chk("flush_yumi", 32'(a_yumi), 32'd1);
    @(posedge clk); #1;
    a_flush = 1'b0;
    a_bv = 1'b0;
    chk("flush_head_after", 32'(a_head), 32'd0);
    chk("flush_gc", a_gc, 32'd13);
    chk("flush_ic", a_ic, 32'd15);

    // empty bundle
    a_d[0] = '0;
    a_d[1] = '0;
    a_bv = 1'b1;
    @(negedge clk);
    chk("empty_issue_v", 32'(a_issue_v), 32'd0);
    chk("empty_yumi", 32'(a_yumi), 32'd1);
    @(posedge clk); #1;
    a_bv = 1'b0;

    // wider bundle: INT, -, FP, INT(reads x5 written by slot0)
    b_ready = 1'b1;
    b_d[0] = iadd(5, 1, 2);
    b_d[1] = '0;
    b_d[2] = fadd(3, 1, 2);
    b_d[3] = iadd(6, 5, 2);
    pb(8'b0101, 1'b0, 4'd0);
    pb(8'b1000, 1'b1, 4'd3);
    run_b("wide_skip");

    // four independent INT ops, limit 2 per group
    b_d[0] = iadd(10, 1, 2);
    b_d[1] = iadd(11, 1, 2);
    b_d[2] = iadd(12, 1, 2);
    b_d[3] = iadd(13, 1, 2);
    pb(8'b0011, 1'b0, 4'd0);
    pb(8'b1100, 1'b1, 4'd2);
    run_b("wide_int_limit");

    // special in slot1 closes the group; slot3 invalid ends the bundle
    b_d[0] = iadd(10, 1, 2);
    b_d[1] = mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1, 1'b1, 2, 1'b0);
    b_d[2] = iadd(11, 1, 2);
    b_d[3] = '0;
    pb(8'b0011, 1'b0, 4'd0);
    pb(8'b0100, 1'b1, 4'd2);
    run_b("wide_special");
    chk("wide_gc", b_gc, 32'd6);
    chk("wide_ic", b_ic, 32'd10);

    // asynchronous reset mid-bundle
    a_d[0] = iadd(5, 1, 2);
    a_d[1] = iadd(6, 3, 4);
    pa(8'b01, 1'b0, 4'd0);
    a_bv = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    a_ready = 1'b0;
    chk("areset_head_before", 32'(a_head), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_head", 32'(a_head), 32'd0);
    chk("areset_mask", 32'(a_mask), 32'b01);
    chk("areset_gc", a_gc, 32'd0);
    chk("areset_ic_b", b_ic, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_bv = 1'b0;
    @(posedge clk); #1;

    chk("final_qa", 32'(qa.size()), 32'd0);
    chk("final_qb", 32'(qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
